// File: rtl/expr_stack_unit.sv
// Expression stack datapath: executes PUSH / POP-1 / POP-2 / DUP / FLIP commands from the
// control unit and presents the top two entries every cycle, with sticky fault flags.
module expr_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             ESAct,
  input  logic [1:0]       ESOp,
  input  logic             popAmt,
  input  logic [WIDTH-1:0] PushData,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] Top,
  output logic [WIDTH-1:0] Second,
  output logic [CNT_W-1:0] Count,
  output logic             Empty,
  output logic             Full,
  output logic             Overflow,
  output logic             Underflow
);

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_DUP  = 2'b10,
    OP_FLIP = 2'b11
  } es_op_e;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             has1, has2, not_full;
  logic [AW-1:0]    top_idx, sec_idx, wr_idx;
  logic             ovf_fault, unf_fault;
  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  // Read side: entries at or above Count hold stale data, so Count gates what is visible.
  always_comb begin
    has1     = (count_q != '0);
    has2     = (count_q >= CNT_W'(2));
    not_full = (count_q < DEPTH_C);
    top_idx  = AW'(count_q - CNT_W'(1));
    sec_idx  = AW'(count_q - CNT_W'(2));
    wr_idx   = AW'(count_q);
    Top      = has1 ? mem_q[top_idx] : '0;
    Second   = has2 ? mem_q[sec_idx] : '0;
    Count    = count_q;
    Empty    = (count_q == '0);
    Full     = (count_q == DEPTH_C);
    Overflow = ovf_q;
    Underflow = unf_q;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    count_d   = count_q;
    ovf_fault = 1'b0;
    unf_fault = 1'b0;
    wr0_en    = 1'b0;
    wr0_idx   = wr_idx;
    wr0_data  = PushData;
    wr1_en    = 1'b0;
    wr1_idx   = sec_idx;
    wr1_data  = Top;

    if (ESAct && !Reset) begin
      case (es_op_e'(ESOp))
        OP_PUSH: begin
          if (not_full) begin
            wr0_en  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_fault = 1'b1;
          end
        end
        OP_POP: begin
          // A two-entry pop with only one entry present is rejected whole, never partial.
          if (popAmt) begin
            if (has2) count_d = count_q - CNT_W'(2);
            else      unf_fault = 1'b1;
          end else begin
            if (has1) count_d = count_q - CNT_W'(1);
            else      unf_fault = 1'b1;
          end
        end
        OP_DUP: begin
          if (!has1) begin
            unf_fault = 1'b1;
          end else if (!not_full) begin
            ovf_fault = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_data = Top;
            count_d  = count_q + CNT_W'(1);
          end
        end
        OP_FLIP: begin
          if (has2) begin
            wr0_en   = 1'b1;
            wr0_idx  = top_idx;
            wr0_data = Second;
            wr1_en   = 1'b1;
          end else begin
            unf_fault = 1'b1;
          end
        end
      endcase
    end

    // A fault in the same cycle as ErrClr wins, so the new fault is never lost.
    ovf_d = (ovf_q & ~ErrClr) | ovf_fault;
    unf_d = (unf_q & ~ErrClr) | unf_fault;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; Count gating keeps its contents invisible
  // until written, and a reset-free array maps onto plain register files.
  always_ff @(posedge CLK) begin
    if (wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (wr1_en) mem_q[wr1_idx] <= wr1_data;
  end

endmodule
